// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared ALU: arbitrates, issues one op, waits with a watchdog.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default is fixed priority to requester 0.
module alu_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       opcode0,
    input  logic [2:0]       opcode1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH:0]   rsp_result,
    output logic             rsp_err,
    output logic             alu_go,
    output logic [2:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_done,
    output logic             led_idle,
    output logic             led_busy
);

    // WAIT counts 0..TIMEOUT-1; the last value forces the abort.
    localparam int CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state;
    logic            grant_id;
    logic [CntW-1:0] wait_cnt;
    logic            pick1;

`ifdef ALU_ARB_RR_EN
    logic rr_ptr;  // 1 means requester 1 wins the next tie
    always_comb pick1 = req1 && (!req0 || rr_ptr);
`else
    always_comb pick1 = req1 && !req0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            grant_id   <= 1'b0;
            wait_cnt   <= '0;
            alu_go     <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            led_idle   <= 1'b1;
            led_busy   <= 1'b0;
`ifdef ALU_ARB_RR_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            alu_go <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            case (state)
                StIdle: begin
                    if (req0 || req1) begin
                        grant_id   <= pick1;
                        alu_opcode <= pick1 ? opcode1 : opcode0;
                        alu_a      <= pick1 ? a1 : a0;
                        alu_b      <= pick1 ? b1 : b0;
                        alu_go     <= 1'b1;
                        led_idle   <= 1'b0;
                        led_busy   <= 1'b1;
                        state      <= StIssue;
`ifdef ALU_ARB_RR_EN
                        rr_ptr     <= ~pick1;
`endif
                    end
                end
                StIssue: begin
                    wait_cnt <= '0;
                    state    <= StWait;
                end
                StWait: begin
                    // A completion on the final count still wins over the timeout.
                    if (alu_done) begin
                        rsp_result <= {alu_cout, alu_result};
                        rsp_err    <= 1'b0;
                        done0      <= ~grant_id;
                        done1      <= grant_id;
                        state      <= StResp;
                    end else if (wait_cnt == CntLast) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        done0      <= ~grant_id;
                        done1      <= grant_id;
                        state      <= StResp;
                    end else begin
                        wait_cnt <= wait_cnt + CntW'(1);
                    end
                end
                StResp: begin
                    led_idle <= 1'b1;
                    led_busy <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
